inst_fetch_unit: RTL and testbench

//  Instruction fetch stage feeding the single-cycle decode/execute core.

---
 rtl/inst_fetch_if.sv | 29 ++
 rtl/inst_fetch_unit.sv | 136 +++++++++++++
 tb/tb_inst_fetch_unit.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_if.sv
// Fetch-stage bundle: redirect input, instruction-memory request/response, and decode handoff.
// The master modport is the fetch unit's view; the slave modport is the environment's view.
interface inst_fetch_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        rsp_ready;
  logic        out_valid;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        out_fault;
  logic        out_misalign;
  logic        out_ready;

  modport master (
    input  redirect_valid, redirect_pc, req_ready, rsp_valid, rsp_data, rsp_err, out_ready,
    output req_valid, req_addr, rsp_ready, out_valid, out_inst, out_pc, out_fault, out_misalign
  );

  modport slave (
    output redirect_valid, redirect_pc, req_ready, rsp_valid, rsp_data, rsp_err, out_ready,
    input  req_valid, req_addr, rsp_ready, out_valid, out_inst, out_pc, out_fault, out_misalign
  );
endinterface

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: one outstanding memory read, registered redirects, {inst, pc} handoff to decode.
//
// state | meaning
// IDLE  | out of reset, choose first fetch
// REQ   | read request presented at fetch_pc
// WAIT  | request accepted, waiting for response
// HOLD  | instruction (or fault) presented to decode
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic         clk,
  input  logic         rst,
  inst_fetch_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

  state_t      state, state_n;
  logic [31:0] fetch_pc, pc_n;
  logic [31:0] pend_pc, pend_n;
  logic        drop, drop_n;
  logic [31:0] inst_q, inst_n;
  logic [31:0] opc_q, opc_n;
  logic        fault_q, fault_n;
  logic        mis_q, mis_n;
  logic        enter;
  logic [31:0] enter_pc;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_IDLE;
      fetch_pc <= RESET_PC;
      pend_pc  <= RESET_PC;
      drop     <= 1'b0;
      inst_q   <= 32'h0;
      opc_q    <= 32'h0;
      fault_q  <= 1'b0;
      mis_q    <= 1'b0;
    end else begin
      state    <= state_n;
      fetch_pc <= pc_n;
      pend_pc  <= pend_n;
      drop     <= drop_n;
      inst_q   <= inst_n;
      opc_q    <= opc_n;
      fault_q  <= fault_n;
      mis_q    <= mis_n;
    end
  end

  always_comb begin
    state_n  = state;
    pc_n     = fetch_pc;
    pend_n   = pend_pc;
    drop_n   = drop;
    inst_n   = inst_q;
    opc_n    = opc_q;
    fault_n  = fault_q;
    mis_n    = mis_q;
    enter    = 1'b0;
    enter_pc = fetch_pc;

    unique case (state)
      S_IDLE: begin
        enter    = 1'b1;
        enter_pc = bus.redirect_valid ? bus.redirect_pc : fetch_pc;
      end
      S_REQ: begin
        // an unaccepted request keeps its address; the redirect target waits in pend_pc
        if (bus.redirect_valid) begin
          drop_n = 1'b1;
          pend_n = bus.redirect_pc;
        end
        if (bus.req_ready) state_n = S_WAIT;
      end
      S_WAIT: begin
        if (bus.rsp_valid) begin
          if (bus.redirect_valid) begin
            drop_n   = 1'b0;
            enter    = 1'b1;
            enter_pc = bus.redirect_pc;
          end else if (drop) begin
            drop_n   = 1'b0;
            enter    = 1'b1;
            enter_pc = pend_pc;
          end else begin
            inst_n  = bus.rsp_err ? 32'h0 : bus.rsp_data;
            opc_n   = fetch_pc;
            fault_n = bus.rsp_err;
            mis_n   = 1'b0;
            state_n = S_HOLD;
          end
        end else if (bus.redirect_valid) begin
          drop_n = 1'b1;
          pend_n = bus.redirect_pc;
        end
      end
      S_HOLD: begin
        // redirect takes priority over a simultaneous consume
        if (bus.redirect_valid) begin
          enter    = 1'b1;
          enter_pc = bus.redirect_pc;
        end else if (bus.out_ready) begin
          enter    = 1'b1;
          enter_pc = fetch_pc + 32'd4;
        end
      end
      default: state_n = S_IDLE;
    endcase

    if (enter) begin
      pc_n = enter_pc;
      if (enter_pc[1:0] != 2'b00) begin
        state_n = S_HOLD;
        inst_n  = 32'h0;
        opc_n   = enter_pc;
        fault_n = 1'b0;
        mis_n   = 1'b1;
      end else begin
        state_n = S_REQ;
        fault_n = 1'b0;
        mis_n   = 1'b0;
      end
    end
  end

  assign bus.req_valid    = (state == S_REQ);
  assign bus.req_addr     = fetch_pc;
  assign bus.rsp_ready    = (state == S_WAIT);
  assign bus.out_valid    = (state == S_HOLD);
  assign bus.out_inst     = inst_q;
  assign bus.out_pc       = opc_q;
  assign bus.out_fault    = fault_q;
  assign bus.out_misalign = mis_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit with a small instruction-memory responder.
// Memory returns {addr[15:0], 16'h0013}, flags rsp_err when addr matches err_addr.
module tb_inst_fetch_unit;

  logic clk;
  logic rst;
  inst_fetch_if bus ();

  inst_fetch_unit #(.RESET_PC(32'h8000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // memory responder: samples the handshake on the edge, updates its outputs just after
  int          rsp_delay;
  logic [31:0] err_addr;
  int          m_cnt;
  logic        m_busy;
  logic        m_acc, m_took, m_rst;
  logic [31:0] m_a, m_addr;

  always @(posedge clk) begin
    m_acc  = bus.req_valid && bus.req_ready;
    m_took = bus.rsp_valid && bus.rsp_ready;
    m_rst  = rst;
    m_a    = bus.req_addr;
    #1;
    if (!m_rst) begin
      m_busy        = 1'b0;
      m_cnt         = 0;
      m_addr        = 32'h0;
      bus.rsp_valid = 1'b0;
      bus.rsp_data  = 32'h0;
      bus.rsp_err   = 1'b0;
    end else begin
      if (m_took) begin
        bus.rsp_valid = 1'b0;
        m_busy        = 1'b0;
      end
      if (m_acc) begin
        m_busy = 1'b1;
        m_cnt  = rsp_delay;
        m_addr = m_a;
      end
      if (m_busy && !bus.rsp_valid) begin
        m_cnt--;
        if (m_cnt == 0) begin
          bus.rsp_valid = 1'b1;
          bus.rsp_data  = {m_addr[15:0], 16'h0013};
          bus.rsp_err   = (m_addr == err_addr);
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req_valid"}, {31'h0, bus.req_valid}, 32'h0);
    chk({tag, "_rsp_ready"}, {31'h0, bus.rsp_ready}, 32'h0);
    chk({tag, "_out_valid"}, {31'h0, bus.out_valid}, 32'h0);
    chk({tag, "_out_fault"}, {31'h0, bus.out_fault}, 32'h0);
    chk({tag, "_out_misalign"}, {31'h0, bus.out_misalign}, 32'h0);
    chk({tag, "_out_inst"}, bus.out_inst, 32'h0);
    chk({tag, "_out_pc"}, bus.out_pc, 32'h0);
    chk({tag, "_req_addr"}, bus.req_addr, 32'h8000_0000);
  endtask

  initial begin
    rst                = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.req_ready      = 1'b1;
    bus.out_ready      = 1'b0;
    rsp_delay          = 1;
    err_addr           = 32'hFFFF_FFFF;

    repeat (2) step();
    chk_reset("rst0");

    // T1: zero-wait memory, one instruction every 3 cycles
    rst           = 1'b1;
    bus.out_ready = 1'b1;
    step();
    for (int k = 0; k < 3; k++) begin
      chk("t1_req_valid", {31'h0, bus.req_valid}, 32'h1);
      chk("t1_req_addr", bus.req_addr, 32'h8000_0000 + 32'(4 * k));
      chk("t1_out_valid_req", {31'h0, bus.out_valid}, 32'h0);
      step();
      chk("t1_rsp_ready", {31'h0, bus.rsp_ready}, 32'h1);
      chk("t1_out_valid_wait", {31'h0, bus.out_valid}, 32'h0);
      step();
      chk("t1_out_valid", {31'h0, bus.out_valid}, 32'h1);
      chk("t1_out_pc", bus.out_pc, 32'h8000_0000 + 32'(4 * k));
      chk("t1_out_inst", bus.out_inst, 32'h0000_0013 | (32'(4 * k) << 16));
      step();
    end

    // T2: decode stalls 5 cycles in HOLD
    chk("t2_req_addr0", bus.req_addr, 32'h8000_000C);
    step();
    step();
    chk("t2_out_valid0", {31'h0, bus.out_valid}, 32'h1);
    bus.out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t2_out_valid", {31'h0, bus.out_valid}, 32'h1);
      chk("t2_out_pc", bus.out_pc, 32'h8000_000C);
      chk("t2_out_inst", bus.out_inst, 32'h000C_0013);
      chk("t2_no_req", {31'h0, bus.req_valid}, 32'h0);
    end
    bus.out_ready = 1'b1;
    step();
    chk("t2_req_valid", {31'h0, bus.req_valid}, 32'h1);
    chk("t2_req_addr", bus.req_addr, 32'h8000_0010);

    // T4: redirect together with consume at 80000010
    step();
    step();
    chk("t4_out_pc", bus.out_pc, 32'h8000_0010);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h8000_0020;
    step();
    bus.redirect_valid = 1'b0;
    chk("t4_req_valid", {31'h0, bus.req_valid}, 32'h1);
    chk("t4_req_addr", bus.req_addr, 32'h8000_0020);
    chk("t4_out_valid", {31'h0, bus.out_valid}, 32'h0);

    // T5: access fault, then misaligned redirect
    err_addr      = 32'h8000_0020;
    bus.out_ready = 1'b0;
    step();
    step();
    chk("t5_out_valid", {31'h0, bus.out_valid}, 32'h1);
    chk("t5_out_fault", {31'h0, bus.out_fault}, 32'h1);
    chk("t5_out_inst", bus.out_inst, 32'h0);
    chk("t5_out_pc", bus.out_pc, 32'h8000_0020);
    chk("t5_no_misalign", {31'h0, bus.out_misalign}, 32'h0);
    step();
    chk("t5_fault_hold", {31'h0, bus.out_fault}, 32'h1);
    chk("t5_valid_hold", {31'h0, bus.out_valid}, 32'h1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h8000_0002;
    step();
    bus.redirect_valid = 1'b0;
    chk("t5_mis_valid", {31'h0, bus.out_valid}, 32'h1);
    chk("t5_misalign", {31'h0, bus.out_misalign}, 32'h1);
    chk("t5_mis_fault", {31'h0, bus.out_fault}, 32'h0);
    chk("t5_mis_pc", bus.out_pc, 32'h8000_0002);
    chk("t5_mis_inst", bus.out_inst, 32'h0);
    chk("t5_mis_no_req", {31'h0, bus.req_valid}, 32'h0);
    step();
    chk("t5_mis_no_req2", {31'h0, bus.req_valid}, 32'h0);
    chk("t5_misalign2", {31'h0, bus.out_misalign}, 32'h1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h8000_0040;
    bus.out_ready      = 1'b1;
    err_addr           = 32'hFFFF_FFFF;
    rsp_delay          = 3;
    step();
    bus.redirect_valid = 1'b0;
    chk("t5_exit_req", {31'h0, bus.req_valid}, 32'h1);
    chk("t5_exit_addr", bus.req_addr, 32'h8000_0040);

    // T3: redirect during a slow response
    step();
    chk("t3_wait", {31'h0, bus.rsp_ready}, 32'h1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h8000_0100;
    step();
    bus.redirect_valid = 1'b0;
    chk("t3_no_out1", {31'h0, bus.out_valid}, 32'h0);
    step();
    chk("t3_no_out2", {31'h0, bus.out_valid}, 32'h0);
    chk("t3_rsp_seen", {31'h0, bus.rsp_valid}, 32'h1);
    step();
    chk("t3_no_out3", {31'h0, bus.out_valid}, 32'h0);
    chk("t3_req_valid", {31'h0, bus.req_valid}, 32'h1);
    chk("t3_req_addr", bus.req_addr, 32'h8000_0100);
    rsp_delay = 1;
    step();
    step();
    chk("t3_out_pc", bus.out_pc, 32'h8000_0100);
    chk("t3_out_inst", bus.out_inst, 32'h0100_0013);

    // T6: request stall with redirect, then reset mid-WAIT
    bus.req_ready = 1'b0;
    step();
    chk("t6_addr0", bus.req_addr, 32'h8000_0104);
    step();
    chk("t6_addr1", bus.req_addr, 32'h8000_0104);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h8000_0200;
    step();
    bus.redirect_valid = 1'b0;
    chk("t6_addr2", bus.req_addr, 32'h8000_0104);
    chk("t6_valid2", {31'h0, bus.req_valid}, 32'h1);
    step();
    chk("t6_addr3", bus.req_addr, 32'h8000_0104);
    bus.req_ready = 1'b1;
    step();
    chk("t6_wait", {31'h0, bus.rsp_ready}, 32'h1);
    chk("t6_no_out", {31'h0, bus.out_valid}, 32'h0);
    step();
    chk("t6_refetch", bus.req_addr, 32'h8000_0200);
    chk("t6_refetch_valid", {31'h0, bus.req_valid}, 32'h1);
    chk("t6_no_out2", {31'h0, bus.out_valid}, 32'h0);
    step();
    chk("t6_wait2", {31'h0, bus.rsp_ready}, 32'h1);
    rst = 1'b0;
    step();
    chk_reset("t6_rst");

    // PC wrap: redirect on an accepted request, then consume at FFFFFFFC
    rst = 1'b1;
    step();
    chk("wrap_first_req", bus.req_addr, 32'h8000_0000);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFC;
    step();
    bus.redirect_valid = 1'b0;
    chk("wrap_wait_no_out", {31'h0, bus.out_valid}, 32'h0);
    step();
    chk("wrap_req_addr", bus.req_addr, 32'hFFFF_FFFC);
    step();
    step();
    chk("wrap_out_pc", bus.out_pc, 32'hFFFF_FFFC);
    chk("wrap_out_inst", bus.out_inst, 32'hFFFC_0013);
    step();
    chk("wrap_next_addr", bus.req_addr, 32'h0000_0000);
    chk("wrap_next_valid", {31'h0, bus.req_valid}, 32'h1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
